instr_mem_loadable: RTL and testbench

- Parametrised, writable instruction memory for the 16-bit MIPS-style core; successor to the fixed-content combinational instruction ROM.
- Adds a registered fetch port with stall, a sequential clear after reset, and a handshaked load port so programs are streamed in at run time instead of being hard-coded.
- Sits between the PC register and the decode stage; the load port is driven by the test/boot controller.

---
 rtl/instr_mem_loadable.sv | 127 ++++++++++++
 tb/tb_instr_mem_loadable.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Writable instruction memory: sequential clear after reset, handshaked program
// load port, and a registered fetch port with stall and out-of-range flag.
module instr_mem_loadable #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_LSB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc,
    input  logic              fetch_en,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              oob,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    // One bit wider than pc so the limit itself never wraps.
    localparam logic [PC_W:0] PC_LIMIT = (PC_W + 1)'(DEPTH) << ADDR_LSB;

    logic [1:0]        state;
    logic [AW-1:0]     clr_ptr;
    logic [AW-1:0]     load_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     fetch_idx;
    logic              fetch_in_range;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign fetch_idx      = pc[ADDR_LSB +: AW];
    assign fetch_in_range = {1'b0, pc} < PC_LIMIT;
    assign busy           = (state != ST_RUN);
    assign load_ready     = (state == ST_LOAD);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_ptr;
        wr_data = '0;
        if (rst_n) begin
            if (state == ST_INIT) begin
                wr_en = 1'b1;
            end else if (state == ST_LOAD && load_valid) begin
                wr_en   = 1'b1;
                wr_addr = load_ptr;
                wr_data = load_data;
            end
        end
    end

    // Storage is left unreset; INIT zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            clr_ptr   <= '0;
            load_ptr  <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (clr_ptr == LAST_IDX) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state    <= ST_LOAD;
                        load_ptr <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        load_ptr <= load_ptr + AW'(1);
                        if (load_ptr == LAST_IDX) begin
                            state     <= ST_RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Fetch register: NOP outside RUN, hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instruction <= '0;
            instr_valid <= 1'b0;
            oob         <= 1'b0;
        end else if (state == ST_RUN) begin
            instr_valid <= fetch_en;
            if (fetch_en) begin
                if (fetch_in_range) begin
                    instruction <= mem[fetch_idx];
                    oob         <= 1'b0;
                end else begin
                    instruction <= '0;
                    oob         <= 1'b1;
                end
            end
        end else begin
            instruction <= '0;
            instr_valid <= 1'b0;
            oob         <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: fetch expectations are queued by the
// stimulus and popped by a monitor whenever instr_valid is seen.
module tb_instr_mem_loadable;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic        fetch_en;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        oob;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [15:0] exp_mem [16];
    logic [15:0] src [16];
    logic [15:0] q_instr [$];
    logic        q_oob [$];

    instr_mem_loadable #(.DATA_W(16), .PC_W(16), .DEPTH(16), .ADDR_LSB(1)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en),
        .instruction(instruction), .instr_valid(instr_valid), .oob(oob),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every valid fetch against the queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && load_done === 1'b1) done_cnt++;
        if (rst_n === 1'b1 && instr_valid === 1'b1) begin
            if (q_instr.size() == 0) begin
                check("unexpected_fetch", 32'(instr_valid), 32'd0);
            end else begin
                check("fetch_instr", 32'(instruction), 32'(q_instr.pop_front()));
                check("fetch_oob", 32'(oob), 32'(q_oob.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] p);
        pc = p;
        fetch_en = 1'b1;
        if (p < 16'd32) begin
            q_instr.push_back(exp_mem[p[4:1]]);
            q_oob.push_back(1'b0);
        end else begin
            q_instr.push_back(16'h0000);
            q_oob.push_back(1'b1);
        end
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        load_valid = 1'b0;
        load_start = 1'b0;
        tick();
        tick();
        check("rst_instruction", 32'(instruction), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_oob", 32'(oob), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            load_start = (n == 3);
            n++;
            tick();
        end
        load_start = 1'b0;
        check("init_busy_cycles", 32'(n), 32'd16);
        check("init_ignores_start", 32'(load_ready), 32'd0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    endtask

    task automatic run_load(input bit gapped, input int abort_after);
        int n;
        int cyc;
        int ready_cycles;
        int done0;
        done0 = done_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n = 0;
        cyc = 0;
        ready_cycles = 0;
        while (n < 16 && cyc < 200) begin
            load_valid = gapped ? (cyc % 2 == 0) : 1'b1;
            load_data  = load_valid ? src[n] : 16'hBAD0 + 16'(cyc);
            load_start = (cyc == 7);
            if (load_ready === 1'b1) ready_cycles++;
            if (load_valid && load_ready === 1'b1) begin
                exp_mem[n] = src[n];
                n++;
            end
            tick();
            cyc++;
            if (n == abort_after) break;
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        if (abort_after < 0) begin
            check("load_done_pulse", 32'(load_done), 32'd1);
            check("load_ready_after", 32'(load_ready), 32'd0);
            check("load_ready_cycles", 32'(ready_cycles), gapped ? 32'd31 : 32'd16);
            tick();
            check("load_done_clears", 32'(load_done), 32'd0);
            check("load_done_count", 32'(done_cnt - done0), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pc = '0;
        fetch_en = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;

        // Reset, clear, and all-zero contents.
        do_reset();
        for (int p = 0; p <= 30; p += 2) fetch(16'(p));

        // Contiguous load with a load_start pulse mid-load.
        src = '{16'h0590, 16'h2CB2, 16'h4008, 16'hDDD9, 16'hFFB1, 16'h1234, 16'h5678, 16'h9ABC,
                16'hDEF0, 16'h0F0F, 16'hF0F0, 16'hA5A5, 16'h5A5A, 16'h1357, 16'h2468, 16'hC3C3};
        run_load(1'b0, -1);
        fetch(16'd2);
        for (int p = 0; p <= 30; p += 2) fetch(16'(p));

        // Out of range and low-bit alignment.
        fetch(16'd32);
        fetch(16'hFFFE);
        fetch(16'd3);

        // Stall holds the last word and drops valid.
        fetch(16'd6);
        pc = 16'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(instr_valid), 32'd0);
            check("stall_hold", 32'(instruction), 32'hDDD9);
        end
        fetch(16'd8);

        // Gapped load; bubbles carry junk data that must not be written.
        for (int i = 0; i < 16; i++) src[i] = 16'h1000 + 16'(i * 16'h0111);
        run_load(1'b1, -1);
        for (int p = 0; p <= 30; p += 2) fetch(16'(p));
        fetch(16'd40);

        // Gapped load aborted by reset after word 5.
        begin
            int done0;
            done0 = done_cnt;
            for (int i = 0; i < 16; i++) src[i] = 16'h7700 + 16'(i);
            run_load(1'b1, 5);
            do_reset();
            check("abort_no_done", 32'(done_cnt - done0), 32'd0);
        end
        for (int p = 0; p <= 30; p += 2) fetch(16'(p));

        tick();
        tick();
        check("queue_drained", 32'(q_instr.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
